// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates an instruction-fetch requester and a data (load/store) requester
// onto a single unified memory port. One access is in flight at a time and
// every access takes exactly three cycles: grant (IDLE sample), memory cycle
// (DATA or FETCH), response cycle (RESP).
//
// Handshake: a requester raises req and holds it, together with its address
// and payload, until its ready output pulses for one cycle. Requests are only
// looked at in IDLE; the payload is latched on the grant edge, so later
// changes on the request inputs have no effect on the access in flight. A
// requester that still has req high in the IDLE cycle after its ready pulse
// is treated as a new request.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   if_req/if_addr      fetch request and byte address
//   if_ready/if_inst    fetch done pulse, registered instruction (held)
//   d_req/d_we/d_addr/d_wdata/d_funct3
//                       data request: store flag, byte address, store data,
//                       RV32I load/store width code
//   d_ready/d_rdata/d_misalign
//                       data done pulse, registered load data, misalign flag
//   mem_read/mem_write/mem_addr/mem_wdata/mem_funct3
//                       memory port drive (idle = all zero)
//   mem_rdata/mem_inst  combinational memory load and fetch outputs
//   fsm_state           current arbiter state (0 IDLE, 1 DATA, 2 FETCH, 3 RESP)
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic [31:0]       if_inst,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [2:0]        d_funct3,
   output logic              d_ready,
   output logic [31:0]       d_rdata,
   output logic              d_misalign,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [2:0]        mem_funct3,
   input  logic [31:0]       mem_rdata,
   input  logic [31:0]       mem_inst,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      FETCH = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state;
   logic              last_grant;    // 0 = data side served last, 1 = fetch side
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic [2:0]        lat_funct3;
   logic              lat_we;
   logic              lat_misalign;

   logic              grant_fetch;
   logic              grant_data;
   logic              req_misalign;
   logic              store_ok;

   // On a tie the side that was not served last wins, so neither requester
   // can starve the other.
   always_comb begin
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      if (if_req && d_req) begin
         grant_fetch = ~last_grant;
         grant_data  = last_grant;
      end else begin
         grant_fetch = if_req;
         grant_data  = d_req;
      end
   end

   // Halfwords need bit 0 clear, words need bits 1:0 clear; bytes and the
   // unused width codes are never misaligned.
   always_comb begin
      req_misalign = 1'b0;
      case (d_funct3)
         3'b001, 3'b101: req_misalign = d_addr[0];
         3'b010:         req_misalign = |d_addr[1:0];
         default:        req_misalign = 1'b0;
      endcase
   end

   // Only SB/SH/SW are real stores; other width codes complete without writing.
   assign store_ok = (lat_funct3 == 3'b000) || (lat_funct3 == 3'b001) ||
                     (lat_funct3 == 3'b010);

   // Memory port is a pure decode of state and latches. The strobes are
   // forced low during reset so a store caught mid-access never lands.
   always_comb begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_funct3 = '0;
      case (state)
         DATA: begin
            mem_addr   = lat_addr;
            mem_funct3 = lat_funct3;
            mem_wdata  = lat_wdata;
            if (!lat_misalign) begin
               if (lat_we) mem_write = store_ok;
               else        mem_read  = 1'b1;
            end
         end
         FETCH: mem_addr = lat_addr;
         default: ;
      endcase
      if (rst) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         last_grant   <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         lat_funct3   <= '0;
         lat_we       <= 1'b0;
         lat_misalign <= 1'b0;
         if_ready     <= 1'b0;
         if_inst      <= '0;
         d_ready      <= 1'b0;
         d_rdata      <= '0;
         d_misalign   <= 1'b0;
      end else begin
         if_ready   <= 1'b0;
         d_ready    <= 1'b0;
         d_misalign <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_fetch) begin
                  state        <= FETCH;
                  last_grant   <= 1'b1;
                  lat_addr     <= if_addr;
                  lat_wdata    <= '0;
                  lat_funct3   <= '0;
                  lat_we       <= 1'b0;
                  lat_misalign <= 1'b0;
               end else if (grant_data) begin
                  state        <= DATA;
                  last_grant   <= 1'b0;
                  lat_addr     <= d_addr;
                  lat_wdata    <= d_wdata;
                  lat_funct3   <= d_funct3;
                  lat_we       <= d_we;
                  lat_misalign <= req_misalign;
               end
            end
            DATA: begin
               state      <= RESP;
               d_ready    <= 1'b1;
               d_misalign <= lat_misalign;
               d_rdata    <= (!lat_we && !lat_misalign) ? mem_rdata : 32'd0;
            end
            FETCH: begin
               state    <= RESP;
               if_ready <= 1'b1;
               if_inst  <= mem_inst;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter. A byte-array memory answers the DUT's memory port;
// a separate reference byte array plus a grant model (tie goes to the side
// not served last) predict every access. Directed cases come first, then
// randomized request mixes.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam logic [1:0] ST_IDLE = 2'd0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req, d_req, d_we;
   logic [8:0]  if_addr, d_addr;
   logic [31:0] d_wdata;
   logic [2:0]  d_funct3;
   logic        if_ready, d_ready, d_misalign;
   logic [31:0] if_inst, d_rdata;
   logic        mem_read, mem_write;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata, mem_inst;
   logic [2:0]  mem_funct3;
   logic [1:0]  fsm_state;

   int          n_cmp = 0;
   int          n_bad = 0;

   logic [7:0]  env_mem [512];
   logic [7:0]  ref_mem [512];
   logic        last_fetch = 1'b0;   // model: most recent grant went to fetch
   logic [31:0] exp_if_inst = '0;
   logic [31:0] exp_d_rdata = '0;
   logic [31:0] exp_q [$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(9)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_inst(if_inst),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_funct3(d_funct3), .d_ready(d_ready), .d_rdata(d_rdata),
      .d_misalign(d_misalign),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
      .mem_rdata(mem_rdata), .mem_inst(mem_inst), .fsm_state(fsm_state)
   );

   // ---------------- environment memory ----------------
   logic [8:0]  env_ha, env_wa;
   logic [15:0] env_h;
   logic [31:0] env_w;

   always_comb begin
      env_ha = {mem_addr[8:1], 1'b0};
      env_wa = {mem_addr[8:2], 2'b00};
      env_h  = {env_mem[env_ha + 9'd1], env_mem[env_ha]};
      env_w  = {env_mem[env_wa + 9'd3], env_mem[env_wa + 9'd2],
                env_mem[env_wa + 9'd1], env_mem[env_wa]};
      mem_inst = env_w;
      case (mem_funct3)
         3'd0:    mem_rdata = {{24{env_mem[mem_addr][7]}}, env_mem[mem_addr]};
         3'd1:    mem_rdata = {{16{env_h[15]}}, env_h};
         3'd4:    mem_rdata = {24'd0, env_mem[mem_addr]};
         3'd5:    mem_rdata = {16'd0, env_h};
         default: mem_rdata = env_w;
      endcase
   end

   always @(posedge clk) begin
      if (mem_write) begin
         env_mem[mem_addr] = mem_wdata[7:0];
         if (mem_funct3 != 3'd0) env_mem[mem_addr + 9'd1] = mem_wdata[15:8];
         if (mem_funct3 == 3'd2) begin
            env_mem[mem_addr + 9'd2] = mem_wdata[23:16];
            env_mem[mem_addr + 9'd3] = mem_wdata[31:24];
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic logic is_mis(input logic [8:0] a, input logic [2:0] f3);
      if (f3 == 3'd1 || f3 == 3'd5) return a[0];
      if (f3 == 3'd2)               return a[1:0] != 2'b00;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_word(input logic [8:0] a);
      int b;
      b = int'(a) & ~3;
      return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
   endfunction

   function automatic logic [31:0] ref_load(input logic [8:0] a, input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      int          ha;
      ha = int'(a) & ~1;
      b  = ref_mem[a];
      h  = {ref_mem[ha+1], ref_mem[ha]};
      case (f3)
         3'd0:    return {{24{b[7]}}, b};
         3'd1:    return {{16{h[15]}}, h};
         3'd4:    return {24'd0, b};
         3'd5:    return {16'd0, h};
         default: return ref_word(a);
      endcase
   endfunction

   task automatic ref_store(input logic [8:0] a, input logic [2:0] f3, input logic [31:0] wd);
      int n;
      n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 512] = wd[8*i +: 8];
   endtask

   task automatic put_word(input int a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         env_mem[a+i] = w[8*i +: 8];
         ref_mem[a+i] = w[8*i +: 8];
      end
   endtask

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check_eq("inv_ready_excl", 32'(if_ready & d_ready), 32'd0);
         if (!d_ready) check_eq("inv_misalign", 32'(d_misalign), 32'd0);
      end
   end

   // ---------------- driver ----------------
   // Called at a negedge while the DUT is in IDLE; returns at the negedge of
   // the next IDLE cycle. With hold set the requests stay asserted.
   task automatic run_txn(input logic iq, input logic dq, input logic [8:0] ia,
                          input logic [8:0] da, input logic we, input logic [2:0] f3,
                          input logic [31:0] wd, input logic hold);
      logic        g_data, mis, rd, wr;
      logic [31:0] res;
      if_req = iq; d_req = dq; if_addr = ia; d_addr = da;
      d_we = we; d_funct3 = f3; d_wdata = wd;
      if (!iq && !dq) begin
         @(negedge clk);
         check_eq("idle_no_ready", 32'({if_ready, d_ready}), 32'd0);
         return;
      end
      g_data = dq && !(iq && !last_fetch);
      mis    = g_data && is_mis(da, f3);
      rd     = g_data && !we && !mis;
      wr     = g_data && we && !mis && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
      if (g_data) exp_d_rdata = rd ? ref_load(da, f3) : 32'd0;
      else        exp_if_inst = ref_word(ia);
      exp_q.push_back(g_data ? exp_d_rdata : exp_if_inst);
      last_fetch = !g_data;

      @(posedge clk);            // grant edge
      @(negedge clk);            // memory cycle
      if (!hold) begin
         if_addr = ia ^ 9'h010; d_addr = da ^ 9'h010; d_wdata = ~wd;
         d_we = ~we; d_funct3 = f3 ^ 3'd1;
      end
      #1;
      check_eq("acc_addr",  32'(mem_addr), 32'(g_data ? da : ia));
      check_eq("acc_read",  32'(mem_read), 32'(rd));
      check_eq("acc_write", 32'(mem_write), 32'(wr));
      if (g_data) check_eq("acc_funct3", 32'(mem_funct3), 32'(f3));
      if (wr)     check_eq("acc_wdata", mem_wdata, wd);
      check_eq("acc_no_ready", 32'({if_ready, d_ready}), 32'd0);

      @(negedge clk);            // response cycle
      res = exp_q.pop_front();
      check_eq("rsp_if_ready", 32'(if_ready), 32'(!g_data));
      check_eq("rsp_d_ready", 32'(d_ready), 32'(g_data));
      check_eq("rsp_misalign", 32'(d_misalign), 32'(mis));
      check_eq("rsp_port_idle", 32'({mem_read, mem_write, mem_addr}), 32'd0);
      if (g_data) begin
         check_eq("rsp_d_rdata", d_rdata, res);
         check_eq("rsp_if_inst_held", if_inst, exp_if_inst);
      end else begin
         check_eq("rsp_if_inst", if_inst, res);
         check_eq("rsp_d_rdata_held", d_rdata, exp_d_rdata);
      end
      if (wr) ref_store(da, f3, wd);
      if (!hold) begin
         if_req = 1'b0; d_req = 1'b0;
      end

      @(negedge clk);            // back in IDLE
      check_eq("idle_ready", 32'({if_ready, d_ready, d_misalign}), 32'd0);
      check_eq("idle_port", 32'({mem_read, mem_write, mem_addr}), 32'd0);
   endtask

   task automatic rst_during_store();
      put_word(9'h010, 32'hCAFEF00D);
      if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 9'h010;
      d_funct3 = 3'b010; d_wdata = 32'h12345678;
      @(posedge clk);            // grant edge
      @(negedge clk);            // store cycle
      rst = 1'b1;
      #1;
      check_eq("rst_mem_write", 32'(mem_write), 32'd0);
      check_eq("rst_mem_read", 32'(mem_read), 32'd0);
      @(negedge clk);
      rst = 1'b0; d_req = 1'b0;
      check_eq("rst_state", 32'(fsm_state), 32'(ST_IDLE));
      check_eq("rst_d_ready", 32'(d_ready), 32'd0);
      check_eq("rst_outs", if_inst | d_rdata, 32'd0);
      check_eq("rst_mem_kept", {env_mem[19], env_mem[18], env_mem[17], env_mem[16]},
               32'hCAFEF00D);
      last_fetch  = 1'b0;
      exp_if_inst = '0;
      exp_d_rdata = '0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [2:0] f3;
      logic [8:0] a;
      if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0;
      d_wdata = 0; d_funct3 = 0;
      for (int i = 0; i < 512; i++) begin
         env_mem[i] = 8'($urandom);
         ref_mem[i] = env_mem[i];
      end
      put_word(9'h004, 32'h00500093);
      put_word(9'h064, 32'hABCDEF98);

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_eq("reset_ready", 32'({if_ready, d_ready, d_misalign}), 32'd0);
      check_eq("reset_data", if_inst | d_rdata, 32'd0);
      check_eq("reset_port", 32'({mem_read, mem_write, mem_addr}), 32'd0);
      check_eq("reset_state", 32'(fsm_state), 32'(ST_IDLE));

      // Both sides held after reset: fetch first, then alternate.
      repeat (6) run_txn(1'b1, 1'b1, 9'h004, 9'h064, 1'b0, 3'b010, 32'd0, 1'b1);

      run_txn(1'b1, 1'b0, 9'h004, 9'h000, 1'b0, 3'b000, 32'd0, 1'b0);
      run_txn(1'b0, 1'b1, 9'h000, 9'h064, 1'b0, 3'b010, 32'd0, 1'b0);
      run_txn(1'b0, 1'b1, 9'h000, 9'h066, 1'b1, 3'b010, 32'h11223344, 1'b0);
      // Address moves 0x020 -> 0x030 during the access.
      run_txn(1'b0, 1'b1, 9'h000, 9'h020, 1'b1, 3'b010, 32'hA5A55A5A, 1'b0);
      run_txn(1'b0, 1'b1, 9'h000, 9'h020, 1'b0, 3'b010, 32'd0, 1'b0);
      run_txn(1'b0, 1'b1, 9'h000, 9'h030, 1'b0, 3'b010, 32'd0, 1'b0);
      run_txn(1'b0, 1'b1, 9'h000, 9'h067, 1'b0, 3'b001, 32'd0, 1'b0);
      run_txn(1'b0, 1'b1, 9'h000, 9'h041, 1'b1, 3'b110, 32'hFFFFFFFF, 1'b0);

      rst_during_store();
      run_txn(1'b1, 1'b1, 9'h004, 9'h010, 1'b0, 3'b010, 32'd0, 1'b0);
      run_txn(1'b0, 1'b1, 9'h000, 9'h010, 1'b0, 3'b010, 32'd0, 1'b0);

      for (int k = 0; k < 250; k++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 3) != 0) begin
            if (f3 == 3'd1 || f3 == 3'd5) a[0] = 1'b0;
            if (f3 == 3'd2) a[1:0] = 2'b00;
         end
         run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 9'($urandom_range(0, 511)), a, 1'($urandom_range(0, 1)),
                 f3, 32'($urandom), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
